mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- MUL_SIZE, 32, systolic array edge; power of two, at least 2.
- V_W, 7, width of the row-count field.
- U_W, 8, width of the output-dimension field.
- LOAD_CYC, 2, activation-preload cycles; at least 1.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-low reset.
- start_i  in  1  command valid.
- start_rdy_o  out  1  command accepted when start_i & start_rdy_o.
- v_rows_i  in  V_W  last row index per tile (rows = v_rows_i+1).
- u_dim_i  in  U_W  output dimension; tile count = u_dim_i >> log2(MUL_SIZE).
- weights_rdy_i  in  1  weight buffer for current tile valid.
- compute_weight_sel_o  out  MUL_SIZE x MUL_SIZE  per-PE weight bank select.
- load_act_o  out  1  activation load enable.
- stall_o  out  1  array stall.
- mac_en_o  out  1  MAC compute enable.
- next_tile_o  out  1  last row of current tile, one-cycle pulse.
- tile_idx_o  out  U_W  current tile index.
- done_o  out  1  command complete, one-cycle pulse.
- err_o  out  1  rejected command, one-cycle pulse.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-003 The block SHALL implement states IDLE, STALL, LOAD, COMPUTE and SWAP.
REQ-004 start_rdy_o SHALL be combinational: high in IDLE, and high in the done_o cycle (chaining); low otherwise.
REQ-005 On acceptance the block SHALL latch v_rows_i and the tile count; if the tile count is 0 it SHALL pulse err_o next cycle and stay IDLE.
REQ-006 A valid acceptance SHALL move the block to STALL next cycle, with the row counter and tile_idx_o at 0.
REQ-007 STALL outputs SHALL be stall_o=1, mac_en_o=0, load_act_o=0.
REQ-008 STALL with weights_rdy_i=1 at tile start (row counter 0 and not resuming) SHALL invert every compute_weight_sel_o bit and enter LOAD.
REQ-009 LOAD SHALL last exactly LOAD_CYC cycles with load_act_o=1, stall_o=1, mac_en_o=0, then enter COMPUTE.
REQ-010 COMPUTE SHALL drive load_act_o=1, stall_o=0, mac_en_o=1, and SHALL increment the row counter each cycle.
REQ-011 COMPUTE with weights_rdy_i=0 SHALL enter STALL in the same cycle's registered outputs (stall_o=1, mac_en_o=0) and hold the row counter.
REQ-012 A stall taken mid-tile SHALL resume directly to COMPUTE when weights_rdy_i returns high, with no select inversion and no LOAD.
REQ-013 next_tile_o SHALL be high in the COMPUTE cycle where row counter == latched v_rows; the row counter SHALL wrap to 0 there.
REQ-014 At next_tile_o on a non-final tile, the block SHALL increment tile_idx_o and enter SWAP.
REQ-015 SWAP SHALL last 2*MUL_SIZE cycles with stall_o=1, mac_en_o=0, load_act_o=0, then return to COMPUTE.
REQ-016 SWAP cycle k (k < MUL_SIZE) SHALL toggle bit MUL_SIZE-1-k of select row 0.
REQ-017 In every SWAP cycle, each select row r>0 SHALL take the previous value of row r-1, forming a diagonal wavefront.
REQ-018 At next_tile_o on the final tile, the block SHALL pulse done_o next cycle and reset tile_idx_o to 0.
REQ-019 After the final tile, if start_i is high in that cycle it SHALL accept the new command and enter STALL (or pulse err_o if its tile count is 0); otherwise it SHALL return to IDLE.
REQ-020 Counters SHALL be sized to never overflow: the row counter is V_W bits, the SWAP counter is log2(MUL_SIZE)+1 bits, and all compares are unsigned.
REQ-021 Simultaneous weights_rdy_i=0 and next_tile_o SHALL give next_tile_o priority; the weights_rdy_i check SHALL then apply on SWAP exit.

Reset
REQ-022 With rst_i=0 at a clock edge, next cycle the block SHALL be in IDLE with stall_o=1 and every other output, all select bits and all counters at 0; start_rdy_o then reads 1.
REQ-023 Reset asserted in any state mid-operation SHALL abort the command with no done_o pulse.

Verification (MUL_SIZE=4, LOAD_CYC=2)
REQ-024 Scenario: start with v_rows=3, u_dim=8, weights_rdy held 1 -> checks:
- all select bits become 1;
- load_act_o high 2 cycles, then 4 mac_en_o cycles and next_tile_o;
- 8 SWAP cycles in which row 0 toggles bits 3,2,1,0;
- 4 more mac_en_o cycles, then a done_o pulse.
REQ-025 Scenario: start with u_dim=3 -> err_o pulses once, busy_o stays 0, start_rdy_o stays 1.
REQ-026 Scenario: weights_rdy dropped for 5 cycles at row 2 -> mac_en_o low 5 cycles, no LOAD, 2 remaining rows complete, row count totals 4.
REQ-027 Scenario: start_i held high with a second command at the final next_tile_o -> done_o pulses and the state goes to STALL without visiting IDLE.
REQ-028 Scenario: rst_i=0 during SWAP -> next cycle IDLE, selects all 0, no done_o pulse.

Source files
------------

// File: rtl/mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_sequencer: sequences activation load, MAC compute and diagonal weight  |
// | bank swaps for a MUL_SIZE x MUL_SIZE systolic array, one tile at a time.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_sequencer #(
  parameter int MUL_SIZE = 32,
  parameter int V_W      = 7,
  parameter int U_W      = 8,
  parameter int LOAD_CYC = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  output logic                               start_rdy_o,
  input  logic [V_W-1:0]                     v_rows_i,
  input  logic [U_W-1:0]                     u_dim_i,
  input  logic                               weights_rdy_i,
  output logic [MUL_SIZE-1:0][MUL_SIZE-1:0]  compute_weight_sel_o,
  output logic                               load_act_o,
  output logic                               stall_o,
  output logic                               mac_en_o,
  output logic                               next_tile_o,
  output logic [U_W-1:0]                     tile_idx_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic                               busy_o
);

  localparam int c_LOG2_MS = $clog2(MUL_SIZE);
  localparam int c_SW_W    = c_LOG2_MS + 1;
  localparam int c_LD_W    = $clog2(LOAD_CYC) + 1;
  localparam logic [c_SW_W-1:0] c_SWAP_LAST = c_SW_W'(2*MUL_SIZE-1);
  localparam logic [c_LD_W-1:0] c_LOAD_LAST = c_LD_W'(LOAD_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STALL   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_SWAP    = 3'd4
  } state_t;

  state_t                             r_state, w_state_nxt;
  logic [V_W-1:0]                     r_row, w_row_nxt;
  logic [V_W-1:0]                     r_vrows, w_vrows_nxt;
  logic [U_W-1:0]                     r_tiles, w_tiles_nxt;
  logic [U_W-1:0]                     r_tile_idx, w_tile_nxt;
  logic [c_SW_W-1:0]                  r_swap_cnt, w_swap_nxt;
  logic [c_LD_W-1:0]                  r_load_cnt, w_load_nxt;
  logic                               r_resume, w_resume_nxt;
  logic                               r_done, w_done_nxt;
  logic                               r_err, w_err_nxt;
  logic [MUL_SIZE-1:0][MUL_SIZE-1:0]  r_sel, w_sel_nxt;

  logic                 w_start_rdy;
  logic                 w_accept;
  logic [U_W-1:0]       w_tiles_in;
  logic                 w_last_row;
  logic                 w_last_tile;
  logic [c_LOG2_MS-1:0] w_swap_bit;

  assign w_start_rdy = (r_state == S_IDLE) || r_done;
  assign w_accept    = start_i && w_start_rdy;
  assign w_tiles_in  = u_dim_i >> c_LOG2_MS;
  assign w_last_row  = (r_state == S_COMPUTE) && (r_row == r_vrows);
  assign w_last_tile = (r_tile_idx == (r_tiles - U_W'(1)));
  // Cycle k of the swap wavefront flips bit MUL_SIZE-1-k of row 0, i.e. ~k.
  assign w_swap_bit  = ~r_swap_cnt[c_LOG2_MS-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_vrows    <= '0;
      r_tiles    <= '0;
      r_tile_idx <= '0;
      r_swap_cnt <= '0;
      r_load_cnt <= '0;
      r_resume   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sel      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_vrows    <= w_vrows_nxt;
      r_tiles    <= w_tiles_nxt;
      r_tile_idx <= w_tile_nxt;
      r_swap_cnt <= w_swap_nxt;
      r_load_cnt <= w_load_nxt;
      r_resume   <= w_resume_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_sel      <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_vrows_nxt  = r_vrows;
    w_tiles_nxt  = r_tiles;
    w_tile_nxt   = r_tile_idx;
    w_swap_nxt   = r_swap_cnt;
    w_load_nxt   = r_load_cnt;
    w_resume_nxt = r_resume;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_sel_nxt    = r_sel;
    if (w_accept) begin
      w_vrows_nxt  = v_rows_i;
      w_tiles_nxt  = w_tiles_in;
      w_row_nxt    = '0;
      w_tile_nxt   = '0;
      w_resume_nxt = 1'b0;
      if (w_tiles_in == '0) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_STALL;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_STALL: begin
          // The done cycle is spent in STALL so a chained command skips IDLE.
          if (r_done) begin
            w_state_nxt = S_IDLE;
          end else if (weights_rdy_i) begin
            if (r_resume) begin
              w_resume_nxt = 1'b0;
              w_state_nxt  = S_COMPUTE;
            end else begin
              w_sel_nxt   = ~r_sel;
              w_load_nxt  = '0;
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (r_load_cnt == c_LOAD_LAST) begin
            w_state_nxt = S_COMPUTE;
          end else begin
            w_load_nxt = r_load_cnt + c_LD_W'(1);
          end
        end
        S_COMPUTE: begin
          if (w_last_row) begin
            w_row_nxt = '0;
            if (w_last_tile) begin
              w_tile_nxt  = '0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_STALL;
            end else begin
              w_tile_nxt  = r_tile_idx + U_W'(1);
              w_swap_nxt  = '0;
              w_state_nxt = S_SWAP;
            end
          end else begin
            w_row_nxt = r_row + V_W'(1);
            if (!weights_rdy_i) begin
              w_resume_nxt = 1'b1;
              w_state_nxt  = S_STALL;
            end
          end
        end
        S_SWAP: begin
          for (int r = 1; r < MUL_SIZE; r++) begin
            w_sel_nxt[r] = r_sel[r-1];
          end
          if (!r_swap_cnt[c_LOG2_MS]) begin
            w_sel_nxt[0][w_swap_bit] = ~r_sel[0][w_swap_bit];
          end
          if (r_swap_cnt == c_SWAP_LAST) begin
            if (weights_rdy_i) begin
              w_state_nxt = S_COMPUTE;
            end else begin
              w_resume_nxt = 1'b1;
              w_state_nxt  = S_STALL;
            end
          end else begin
            w_swap_nxt = r_swap_cnt + c_SW_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign start_rdy_o          = w_start_rdy;
  assign compute_weight_sel_o = r_sel;
  assign load_act_o           = (r_state == S_LOAD) || (r_state == S_COMPUTE);
  assign mac_en_o             = (r_state == S_COMPUTE);
  assign stall_o              = (r_state != S_COMPUTE);
  assign next_tile_o          = w_last_row;
  assign tile_idx_o           = r_tile_idx;
  assign done_o               = r_done;
  assign err_o                = r_err;
  assign busy_o               = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// Bench for mac_sequencer (MUL_SIZE=4, LOAD_CYC=2): directed commands with a
// scoreboard of expected output events checked by an independent monitor.
module tb_mac_sequencer;
  localparam int MS = 4;
  localparam int VW = 7;
  localparam int UW = 8;
  localparam logic [2:0] K_SEL = 3'd0, K_LOAD = 3'd1, K_MAC = 3'd2, K_DONE = 3'd3, K_ERR = 3'd4;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic weights_rdy_i = 1'b1;
  logic [VW-1:0] v_rows_i = '0;
  logic [UW-1:0] u_dim_i = '0;
  logic start_rdy_o, load_act_o, stall_o, mac_en_o, next_tile_o, done_o, err_o, busy_o;
  logic [MS-1:0][MS-1:0] sel;
  logic [UW-1:0] tile_idx_o;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } ev_t;
  ev_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] prev_sel;
  int gap = 0;

  mac_sequencer #(.MUL_SIZE(MS), .V_W(VW), .U_W(UW), .LOAD_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .start_rdy_o(start_rdy_o),
    .v_rows_i(v_rows_i), .u_dim_i(u_dim_i), .weights_rdy_i(weights_rdy_i),
    .compute_weight_sel_o(sel), .load_act_o(load_act_o), .stall_o(stall_o),
    .mac_en_o(mac_en_o), .next_tile_o(next_tile_o), .tile_idx_o(tile_idx_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mac_v(int g, logic nt, logic [7:0] t);
    return {15'b0, 8'(g), nt, t};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_ev(logic [2:0] kind, logic [31:0] val);
    sb.push_back('{kind: kind, val: val});
  endtask

  task automatic got(logic [2:0] kind, logic [31:0] val, string name);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event actual kind=%0d val=%h required none", name, kind, val);
    end else begin
      e = sb.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        errors++;
        $display("FAIL %s actual kind=%0d val=%h required kind=%0d val=%h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic issue(logic [VW-1:0] v, logic [UW-1:0] u);
    @(posedge clk); #1;
    start_i = 1'b1; v_rows_i = v; u_dim_i = u;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Monitor: every observable event is popped and compared in cycle order.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sel !== prev_sel) begin
          got(K_SEL, {16'b0, sel}, "sel");
          prev_sel = sel;
        end
        if (load_act_o && !mac_en_o) begin
          got(K_LOAD, {24'b0, tile_idx_o}, "load");
          gap = 0;
        end else if (mac_en_o) begin
          got(K_MAC, mac_v(gap, next_tile_o, tile_idx_o), "mac");
          gap = 0;
        end else if (gap < 255) begin
          gap++;
        end
        if (done_o) got(K_DONE, {30'b0, busy_o, start_rdy_o}, "done");
        if (err_o)  got(K_ERR, {30'b0, busy_o, start_rdy_o}, "err");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit idle_seen;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_start_rdy", start_rdy_o, 1);
    chk("rst_ctrl", {load_act_o, mac_en_o, next_tile_o, done_o, err_o}, 0);
    chk("rst_tile", tile_idx_o, 0);
    chk("rst_sel", sel, 0);
    prev_sel = sel;
    mon_en = 1'b1;

    // Two tiles of four rows with a full diagonal swap between them.
    exp_ev(K_SEL, 32'hFFFF);
    repeat (2) exp_ev(K_LOAD, 0);
    repeat (3) exp_ev(K_MAC, mac_v(0, 0, 0));
    exp_ev(K_MAC, mac_v(0, 1, 0));
    exp_ev(K_SEL, 32'hFFF7); exp_ev(K_SEL, 32'hFF73); exp_ev(K_SEL, 32'hF731);
    exp_ev(K_SEL, 32'h7310); exp_ev(K_SEL, 32'h3100); exp_ev(K_SEL, 32'h1000);
    exp_ev(K_SEL, 32'h0000);
    exp_ev(K_MAC, mac_v(8, 0, 1));
    repeat (2) exp_ev(K_MAC, mac_v(0, 0, 1));
    exp_ev(K_MAC, mac_v(0, 1, 1));
    exp_ev(K_DONE, 32'h3);
    issue(7'd3, 8'd8);
    repeat (25) @(posedge clk);

    // Zero tile count is rejected without leaving IDLE.
    exp_ev(K_ERR, 32'h1);
    issue(7'd3, 8'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_busy", busy_o, 0);
      chk("err_start_rdy", start_rdy_o, 1);
    end
    repeat (3) @(posedge clk);

    // Weights drop for 5 cycles after two rows; the tile resumes without LOAD.
    exp_ev(K_SEL, 32'hFFFF);
    repeat (2) exp_ev(K_LOAD, 0);
    repeat (2) exp_ev(K_MAC, mac_v(0, 0, 0));
    exp_ev(K_MAC, mac_v(5, 0, 0));
    exp_ev(K_MAC, mac_v(0, 1, 0));
    exp_ev(K_DONE, 32'h3);
    issue(7'd3, 8'd4);
    repeat (4) @(posedge clk);
    #1 weights_rdy_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 weights_rdy_i = 1'b1;
    repeat (10) @(posedge clk);

    // A second command chained on the done cycle never returns to IDLE.
    exp_ev(K_SEL, 32'h0000);
    repeat (2) exp_ev(K_LOAD, 0);
    exp_ev(K_MAC, mac_v(0, 0, 0));
    exp_ev(K_MAC, mac_v(0, 1, 0));
    exp_ev(K_DONE, 32'h3);
    exp_ev(K_SEL, 32'hFFFF);
    repeat (2) exp_ev(K_LOAD, 0);
    exp_ev(K_MAC, mac_v(0, 1, 0));
    exp_ev(K_DONE, 32'h3);
    issue(7'd1, 8'd4);
    repeat (4) @(posedge clk);
    #1 start_i = 1'b1; v_rows_i = 7'd0; u_dim_i = 8'd4;
    idle_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!busy_o) idle_seen = 1'b1;
      if (i == 2) start_i = 1'b0;
    end
    chk("chain_no_idle", {31'b0, idle_seen}, 0);
    repeat (10) @(posedge clk);

    // Reset in the middle of a swap aborts with no done pulse.
    exp_ev(K_SEL, 32'h0000);
    repeat (2) exp_ev(K_LOAD, 0);
    exp_ev(K_MAC, mac_v(0, 1, 0));
    exp_ev(K_SEL, 32'h0008);
    exp_ev(K_SEL, 32'h008C);
    exp_ev(K_SEL, 32'h0000);
    issue(7'd0, 8'd8);
    repeat (6) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_stall", stall_o, 1);
    chk("abort_tile", tile_idx_o, 0);
    chk("abort_start_rdy", start_rdy_o, 1);
    repeat (10) @(posedge clk);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
